// File: rtl/pe_pkg.sv
// Shared types and constants for the PE operand feeder.
package pe_pkg;

    // Default operand word width (IEEE-754 single, carried as raw bits).
    localparam int DEFAULT_DATA_WIDTH = 32;

    // Floating-point +0.0; used as the partial sum outside the seeded block.
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    // Feeder control states.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Index width for a table of n entries, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_operand_feeder_if.sv
// Handshake bundle between the operand feeder and its environment.
// master: the feeder itself. slave: the producer/PE side that talks to it.
interface pe_operand_feeder_if
    import pe_pkg::*;
#(
    parameter int DataWidth  = DEFAULT_DATA_WIDTH,
    parameter int CountWidth = 8
);

    // Weight load stream.
    logic                  wload_valid;
    logic                  wload_rdy;
    logic [DataWidth-1:0]  wload_data;

    // Activation push stream.
    logic                  in_valid;
    logic                  in_rdy;
    logic [DataWidth-1:0]  in_data;

    // Block-0 partial-sum stream.
    logic                  ps_valid;
    logic                  ps_rdy;
    logic [DataWidth-1:0]  ps_data;

    // Run command.
    logic                  start_valid;
    logic                  start_rdy;
    logic [CountWidth-1:0] start_blocks;
    logic                  start_psum_en;

    // Operand streams into the PE.
    logic [DataWidth-1:0]  W_DataOut;
    logic                  W_DataOutValid;
    logic                  W_DataOutRdy;
    logic [DataWidth-1:0]  I_DataOut;
    logic                  I_DataOutValid;
    logic                  I_DataOutRdy;
    logic [DataWidth-1:0]  O_DataOut;
    logic                  O_DataOutValid;
    logic                  O_DataOutRdy;

    // Status.
    logic                  busy;
    logic                  done;

    modport master (
        input  wload_valid, wload_data,
        output wload_rdy,
        input  in_valid, in_data,
        output in_rdy,
        input  ps_valid, ps_data,
        output ps_rdy,
        input  start_valid, start_blocks, start_psum_en,
        output start_rdy,
        output W_DataOut, W_DataOutValid,
        input  W_DataOutRdy,
        output I_DataOut, I_DataOutValid,
        input  I_DataOutRdy,
        output O_DataOut, O_DataOutValid,
        input  O_DataOutRdy,
        output busy, done
    );

    modport slave (
        output wload_valid, wload_data,
        input  wload_rdy,
        output in_valid, in_data,
        input  in_rdy,
        output ps_valid, ps_data,
        input  ps_rdy,
        output start_valid, start_blocks, start_psum_en,
        input  start_rdy,
        input  W_DataOut, W_DataOutValid,
        output W_DataOutRdy,
        input  I_DataOut, I_DataOutValid,
        output I_DataOutRdy,
        input  O_DataOut, O_DataOutValid,
        output O_DataOutRdy,
        input  busy, done
    );

endinterface

// File: rtl/pe_feed_fifo.sv
// Synchronous activation FIFO. Full/empty come straight from the registered
// occupancy count, so there is no push-to-pop bypass: a word written into an
// empty FIFO becomes visible on pop_data_o one cycle later.
module pe_feed_fifo
    import pe_pkg::*;
#(
    parameter int DataWidth   = DEFAULT_DATA_WIDTH,
    parameter int BufferWidth = 4,
    parameter int BufferSize  = 16
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] push_data_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] pop_data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam logic [BufferWidth:0] CountFull = (BufferWidth + 1)'(BufferSize);

    logic [DataWidth-1:0]   mem [BufferSize];
    logic [BufferWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [BufferWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [BufferWidth:0]   count_q, count_d;
    logic                   push_ok;
    logic                   pop_ok;

    assign full_o     = (count_q == CountFull);
    assign empty_o    = (count_q == '0);
    assign pop_data_o = mem[rd_ptr_q];

    // Pointer and occupancy next-state; pushes are dropped when full, pops when empty.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        push_ok  = push_i && !full_o;
        pop_ok   = pop_i && !empty_o;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + BufferWidth'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + BufferWidth'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (BufferWidth + 1)'(1);
            2'b01:   count_d = count_q - (BufferWidth + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        if (aclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the cleared pointers make stale words unreachable.
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pe_operand_feeder.sv
// Operand feeder for one PE: holds a block of stationary weights, buffers
// activations and issues {weight, input, psum} beats on three independent
// valid/ready channels. A new beat issues as soon as every channel of the
// previous one has been (or is being) accepted, so the steady rate is one
// beat per cycle.
module pe_operand_feeder
    import pe_pkg::*;
#(
    parameter int DataWidth   = DEFAULT_DATA_WIDTH,
    parameter int BlockLen    = 4,
    parameter int BufferWidth = 4,
    parameter int BufferSize  = 16,
    parameter int CountWidth  = 8
) (
    input  logic              clk,
    input  logic              aclr,
    pe_operand_feeder_if.master bus
);

    localparam int BeatWidth = idx_width(BlockLen);
    localparam int WcntWidth = $clog2(BlockLen + 1);

    typedef logic [BeatWidth-1:0] beat_t;

    localparam beat_t                LastBeat = beat_t'(BlockLen - 1);
    localparam logic [WcntWidth-1:0] WcntFull = WcntWidth'(BlockLen);

    // Weight block; contents survive reset, only the fill count is cleared.
    logic [DataWidth-1:0]  weight_q [BlockLen];

    state_e                state_q, state_d;
    logic [WcntWidth-1:0]  wcnt_q, wcnt_d;
    beat_t                 beat_q, beat_d;
    logic [CountWidth-1:0] blk_q, blk_d;
    logic [CountWidth-1:0] blocks_q, blocks_d;
    logic                  psum_en_q, psum_en_d;
    logic                  issued_all_q, issued_all_d;
    logic                  pw_q, pw_d;
    logic                  pi_q, pi_d;
    logic                  po_q, po_d;
    logic [DataWidth-1:0]  w_out_q, w_out_d;
    logic [DataWidth-1:0]  i_out_q, i_out_d;
    logic [DataWidth-1:0]  o_out_q, o_out_d;
    logic                  done_q, done_d;

    logic                  wload_rdy_c;
    logic                  start_rdy_c;
    logic                  ps_rdy_c;
    logic                  need_ps;
    logic                  slot_free;
    logic                  issue;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DataWidth-1:0]  fifo_data;

    pe_feed_fifo #(
        .DataWidth   (DataWidth),
        .BufferWidth (BufferWidth),
        .BufferSize  (BufferSize)
    ) u_fifo (
        .clk         (clk),
        .aclr        (aclr),
        .push_i      (bus.in_valid),
        .push_data_i (bus.in_data),
        .pop_i       (issue),
        .pop_data_o  (fifo_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign bus.in_rdy         = !fifo_full;
    assign bus.wload_rdy      = wload_rdy_c;
    assign bus.start_rdy      = start_rdy_c;
    assign bus.ps_rdy         = ps_rdy_c;
    assign bus.W_DataOut      = w_out_q;
    assign bus.I_DataOut      = i_out_q;
    assign bus.O_DataOut      = o_out_q;
    assign bus.W_DataOutValid = pw_q;
    assign bus.I_DataOutValid = pi_q;
    assign bus.O_DataOutValid = po_q;
    assign bus.busy           = (state_q == RUN);
    assign bus.done           = done_q;

    // Next-state, weight loading, run start and beat issue.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        beat_d       = beat_q;
        blk_d        = blk_q;
        blocks_d     = blocks_q;
        psum_en_d    = psum_en_q;
        issued_all_d = issued_all_q;
        w_out_d      = w_out_q;
        i_out_d      = i_out_q;
        o_out_d      = o_out_q;
        done_d       = 1'b0;
        issue        = 1'b0;
        ps_rdy_c     = 1'b0;

        wload_rdy_c = (state_q == IDLE) && (wcnt_q < WcntFull);
        start_rdy_c = (state_q == IDLE) && (wcnt_q == WcntFull);

        // A pending channel stays pending until its PE side accepts it.
        pw_d = pw_q && !bus.W_DataOutRdy;
        pi_d = pi_q && !bus.I_DataOutRdy;
        po_d = po_q && !bus.O_DataOutRdy;

        // Slot is free when nothing is left pending after this cycle's acceptances.
        slot_free = !pw_d && !pi_d && !po_d;
        need_ps   = psum_en_q && (blk_q == '0);

        if (wload_rdy_c && bus.wload_valid) begin
            wcnt_d = wcnt_q + WcntWidth'(1);
        end

        case (state_q)
            IDLE: begin
                if (start_rdy_c && bus.start_valid) begin
                    blocks_d     = bus.start_blocks;
                    psum_en_d    = bus.start_psum_en;
                    beat_d       = '0;
                    blk_d        = '0;
                    issued_all_d = 1'b0;
                    if (bus.start_blocks == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                if (issued_all_q) begin
                    // Last beat already issued: finish once it has fully drained.
                    if (slot_free) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else if (slot_free && !fifo_empty && (!need_ps || bus.ps_valid)) begin
                    issue    = 1'b1;
                    ps_rdy_c = need_ps;
                    pw_d     = 1'b1;
                    pi_d     = 1'b1;
                    po_d     = 1'b1;
                    w_out_d  = weight_q[beat_q];
                    i_out_d  = fifo_data;
                    o_out_d  = need_ps ? bus.ps_data : DataWidth'(FP_ZERO);
                    if (beat_q == LastBeat) begin
                        beat_d = '0;
                        blk_d  = blk_q + CountWidth'(1);
                        if (blk_q == blocks_q - CountWidth'(1)) begin
                            issued_all_d = 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + BeatWidth'(1);
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Control and output registers; reset drops any beat in flight.
    always_ff @(posedge clk) begin
        if (aclr) begin
            state_q      <= IDLE;
            wcnt_q       <= '0;
            beat_q       <= '0;
            blk_q        <= '0;
            blocks_q     <= '0;
            psum_en_q    <= 1'b0;
            issued_all_q <= 1'b0;
            pw_q         <= 1'b0;
            pi_q         <= 1'b0;
            po_q         <= 1'b0;
            w_out_q      <= '0;
            i_out_q      <= '0;
            o_out_q      <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            beat_q       <= beat_d;
            blk_q        <= blk_d;
            blocks_q     <= blocks_d;
            psum_en_q    <= psum_en_d;
            issued_all_q <= issued_all_d;
            pw_q         <= pw_d;
            pi_q         <= pi_d;
            po_q         <= po_d;
            w_out_q      <= w_out_d;
            i_out_q      <= i_out_d;
            o_out_q      <= o_out_d;
            done_q       <= done_d;
        end
    end

    // Weight block write port, filled in index order while idle.
    always_ff @(posedge clk) begin
        if (wload_rdy_c && bus.wload_valid) begin
            weight_q[beat_t'(wcnt_q)] <= bus.wload_data;
        end
    end

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Directed bench for pe_operand_feeder: reset state, full-rate runs, a
// stalled input channel, FIFO fill limit, psum starvation and mid-run reset.
module tb_pe_operand_feeder;

    logic clk;
    logic aclr;

    int checks = 0;
    int errors = 0;

    pe_operand_feeder_if #(.DataWidth(32), .CountWidth(8)) bus ();

    pe_operand_feeder #(
        .DataWidth   (32),
        .BlockLen    (4),
        .BufferWidth (4),
        .BufferSize  (16),
        .CountWidth  (8)
    ) dut (
        .clk  (clk),
        .aclr (aclr),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Accepted beats, recorded one half-cycle before the accepting edge.
    logic [31:0] w_q[$];
    logic [31:0] i_q[$];
    logic [31:0] o_q[$];
    int          w_cyc[$];
    int          cyc      = 0;
    int          done_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        if (!aclr) begin
            if (bus.W_DataOutValid && bus.W_DataOutRdy) begin
                w_q.push_back(bus.W_DataOut);
                w_cyc.push_back(cyc);
            end
            if (bus.I_DataOutValid && bus.I_DataOutRdy) i_q.push_back(bus.I_DataOut);
            if (bus.O_DataOutValid && bus.O_DataOutRdy) o_q.push_back(bus.O_DataOut);
            if (bus.done) done_cnt++;
        end
    end

    // Psum source: presents the head of ps_src whenever it is non-empty.
    logic [31:0] ps_src[$];

    initial begin
        bit fire;
        bus.ps_valid = 1'b0;
        bus.ps_data  = '0;
        forever begin
            @(negedge clk);
            fire = bus.ps_valid && bus.ps_rdy && !aclr;
            @(posedge clk);
            #1;
            if (fire && ps_src.size() != 0) void'(ps_src.pop_front());
            bus.ps_valid = (ps_src.size() != 0);
            bus.ps_data  = (ps_src.size() != 0) ? ps_src[0] : 32'h0;
        end
    end

    function automatic logic [31:0] fp(input int n);
        case (n)
            1:  return 32'h3f800000;
            2:  return 32'h40000000;
            3:  return 32'h40400000;
            4:  return 32'h40800000;
            5:  return 32'h40a00000;
            6:  return 32'h40c00000;
            7:  return 32'h40e00000;
            8:  return 32'h41000000;
            9:  return 32'h41100000;
            10: return 32'h41200000;
            11: return 32'h41300000;
            12: return 32'h41400000;
            13: return 32'h41500000;
            14: return 32'h41600000;
            15: return 32'h41700000;
            16: return 32'h41800000;
            17: return 32'h41880000;
            20: return 32'h41a00000;
            30: return 32'h41f00000;
            40: return 32'h42200000;
            default: return 32'hdeadbeef;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        aclr              = 1'b1;
        bus.wload_valid   = 1'b0;
        bus.wload_data    = '0;
        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        bus.start_valid   = 1'b0;
        bus.start_blocks  = '0;
        bus.start_psum_en = 1'b0;
        bus.W_DataOutRdy  = 1'b1;
        bus.I_DataOutRdy  = 1'b1;
        bus.O_DataOutRdy  = 1'b1;
        repeat (2) tick();
        aclr = 1'b0;
    endtask

    task automatic load_weights(input string tag);
        for (int k = 0; k < 4; k++) begin
            bus.wload_valid = 1'b1;
            bus.wload_data  = fp(5 * (k + 1));
            tick();
        end
        bus.wload_valid = 1'b0;
        check({tag, "_start_rdy"}, 32'(bus.start_rdy), 32'd1);
        check({tag, "_wload_rdy"}, 32'(bus.wload_rdy), 32'd0);
    endtask

    task automatic push_words(input int first, input int n);
        for (int k = 0; k < n; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = fp(first + k);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic start_run(input string tag, input int blocks, input bit psum_en);
        bus.start_valid   = 1'b1;
        bus.start_blocks  = 8'(blocks);
        bus.start_psum_en = psum_en;
        check({tag, "_start_rdy_at_cmd"}, 32'(bus.start_rdy), 32'd1);
        tick();
        bus.start_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base_done, input int max_cycles);
        for (int c = 0; c < max_cycles; c++) begin
            if (done_cnt > base_done) break;
            tick();
        end
        check({tag, "_done"}, 32'(done_cnt - base_done), 32'd1);
    endtask

    // Compares a 16-beat, 4-block run with psum seeded in block 0.
    task automatic check_run(input string tag, input int base);
        check({tag, "_nbeats"}, 32'(w_q.size() - base), 32'd16);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("%s_w%0d", tag, k), w_q[base + k], fp(5 * ((k % 4) + 1)));
            check($sformatf("%s_i%0d", tag, k), i_q[base + k], fp(k + 1));
            check($sformatf("%s_o%0d", tag, k), o_q[base + k], (k < 4) ? fp(10 * (k + 1)) : 32'h0);
        end
    endtask

    initial begin
        int base;
        int base_done;
        int acc;

        // 1: reset state
        reset_dut();
        check("rst_valids", {29'd0, bus.W_DataOutValid, bus.I_DataOutValid, bus.O_DataOutValid}, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_in_rdy", 32'(bus.in_rdy), 32'd1);
        check("rst_wload_rdy", 32'(bus.wload_rdy), 32'd1);
        check("rst_start_rdy", 32'(bus.start_rdy), 32'd0);
        check("rst_ps_rdy", 32'(bus.ps_rdy), 32'd0);

        // 2: full-rate run, 4 blocks, psum seeded
        load_weights("t2");
        push_words(1, 16);
        ps_src = '{fp(10), fp(20), fp(30), fp(40)};
        tick();
        base      = w_q.size();
        base_done = done_cnt;
        start_run("t2", 4, 1'b1);
        check("t2_busy", 32'(bus.busy), 32'd1);
        wait_done("t2", base_done, 100);
        check_run("t2", base);
        check("t2_rate", 32'(w_cyc[base + 15] - w_cyc[base]), 32'd15);
        repeat (3) tick();
        check("t2_done_once", 32'(done_cnt - base_done), 32'd1);
        check("t2_idle", 32'(bus.busy), 32'd0);

        // 3: I channel stalled for 3 cycles on beat 2
        push_words(1, 16);
        ps_src = '{fp(10), fp(20), fp(30), fp(40)};
        tick();
        base      = w_q.size();
        base_done = done_cnt;
        start_run("t3", 4, 1'b1);
        for (int c = 0; c < 50; c++) begin
            if (bus.I_DataOutValid && bus.I_DataOut == fp(3)) break;
            tick();
        end
        bus.I_DataOutRdy = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            check($sformatf("t3_i_hold%0d", s), bus.I_DataOut, fp(3));
            check($sformatf("t3_i_valid%0d", s), 32'(bus.I_DataOutValid), 32'd1);
            check($sformatf("t3_wo_idle%0d", s), {30'd0, bus.W_DataOutValid, bus.O_DataOutValid}, 32'd0);
        end
        bus.I_DataOutRdy = 1'b1;
        tick();
        check("t3_beat3_w", bus.W_DataOut, fp(20));
        check("t3_beat3_i", bus.I_DataOut, fp(4));
        wait_done("t3", base_done, 100);
        check_run("t3", base);

        // 4: FIFO capacity, 17 pushes with nothing draining
        acc = 0;
        for (int k = 0; k < 17; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = fp(k + 1);
            if (k == 16) check("t4_in_rdy_17th", 32'(bus.in_rdy), 32'd0);
            if (bus.in_rdy) acc++;
            tick();
        end
        bus.in_valid = 1'b0;
        check("t4_accepted", 32'(acc), 32'd16);
        check("t4_in_rdy", 32'(bus.in_rdy), 32'd0);

        // 5: psum starvation, then release
        base      = w_q.size();
        base_done = done_cnt;
        start_run("t5", 1, 1'b1);
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("t5_novalid%0d", c), {29'd0, bus.W_DataOutValid, bus.I_DataOutValid, bus.O_DataOutValid}, 32'd0);
            check($sformatf("t5_ps_rdy%0d", c), 32'(bus.ps_rdy), 32'd0);
        end
        ps_src = '{fp(10), fp(10), fp(10), fp(10)};
        wait_done("t5", base_done, 60);
        check("t5_w0", w_q[base], fp(5));
        check("t5_i0", i_q[base], fp(1));
        check("t5_o0", o_q[base], fp(10));
        check("t5_i3", i_q[base + 3], fp(4));

        // 6: reset in the middle of a run
        reset_dut();
        load_weights("t6");
        push_words(1, 16);
        ps_src = '{fp(10), fp(20), fp(30), fp(40)};
        tick();
        base = i_q.size();
        start_run("t6", 4, 1'b1);
        for (int c = 0; c < 60; c++) begin
            if (i_q.size() - base >= 6) break;
            tick();
        end
        check("t6_beat6_shown", bus.I_DataOut, fp(7));
        aclr = 1'b1;
        tick();
        aclr = 1'b0;
        check("t6_valids", {29'd0, bus.W_DataOutValid, bus.I_DataOutValid, bus.O_DataOutValid}, 32'd0);
        check("t6_busy", 32'(bus.busy), 32'd0);
        check("t6_start_rdy", 32'(bus.start_rdy), 32'd0);
        check("t6_wload_rdy", 32'(bus.wload_rdy), 32'd1);
        check("t6_in_rdy", 32'(bus.in_rdy), 32'd1);
        load_weights("t6r");
        base_done = done_cnt;
        start_run("t6z", 0, 1'b0);
        check("t6z_done", 32'(bus.done), 32'd1);
        check("t6z_busy", 32'(bus.busy), 32'd0);
        tick();
        check("t6z_done_drop", 32'(bus.done), 32'd0);
        repeat (3) tick();
        check("t6z_nobeats", 32'(i_q.size() - base), 32'd6);
        check("t6z_done_once", 32'(done_cnt - base_done), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
